filters_mul_pipe: RTL and testbench

FILTERS_MUL_PIPE -- requirements
Module: filters_mul_pipe

---
 rtl/filters_mul_pkg.sv | 46 ++++
 rtl/filters_mul_pipe_dsp.sv | 28 ++
 rtl/filters_mul_pipe.sv | 125 ++++++++++++
 tb/tb_filters_mul_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/filters_mul_pkg.sv
// Shared constants and helpers for the pipelined signed x unsigned multiplier.
// Build option: define FILTERS_MUL_SAT_EN to clamp results instead of wrapping.
package filters_mul_pkg;

  // Legal parameter ranges for filters_mul_pipe.
  localparam int DIN0_W_MIN    = 2;
  localparam int DIN0_W_MAX    = 25;
  localparam int DIN1_W_MIN    = 1;
  localparam int DIN1_W_MAX    = 17;
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 6;

  // Working width for rounding/saturation: widest product plus headroom so
  // the rounding addend can never overflow.
  localparam int ACC_W = DIN0_W_MAX + DIN1_W_MAX + 2;

  // Half-LSB addend for round-half-up before an arithmetic right shift.
  function automatic logic signed [ACC_W-1:0] round_const(input int shift);
    logic signed [ACC_W-1:0] c;
    c = '0;
    if (shift > 0) c[shift-1] = 1'b1;
    return c;
  endfunction

  // Largest positive value representable in a signed dout_w-bit result.
  function automatic logic signed [ACC_W-1:0] sat_hi(input int dout_w);
    logic signed [ACC_W-1:0] h;
    h = '0;
    h[dout_w-1] = 1'b1;
    return h - 1;
  endfunction

  // True when r does not fit a signed dout_w-bit result.
  function automatic logic is_sat(input logic signed [ACC_W-1:0] r, input int dout_w);
    return (r > sat_hi(dout_w)) || (r < -sat_hi(dout_w) - 1);
  endfunction

  // Clamp r into the signed dout_w-bit range.
  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] r,
                                                        input int dout_w);
    if (r > sat_hi(dout_w)) return sat_hi(dout_w);
    if (r < -sat_hi(dout_w) - 1) return -sat_hi(dout_w) - 1;
    return r;
  endfunction

endpackage

// File: rtl/filters_mul_pipe_dsp.sv
// Registered multiply core: first pipeline stage, shaped for DSP inference.
module filters_mul_pipe_dsp #(
  parameter int A_W = 17,
  parameter int B_W = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic signed [A_W-1:0]    i_a,
  input  logic        [B_W-1:0]    i_b,
  output logic signed [A_W+B_W-1:0] o_p
);

  // Unsigned multiplier gets a zero sign bit so a signed multiply is exact.
  logic signed [B_W:0]       w_b_ext;
  logic signed [A_W+B_W-1:0] r_p;

  assign w_b_ext = {1'b0, i_b};

  // Capture the full product whenever the pipeline advances; hold on stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_p <= '0;
    else if (i_en) r_p <= i_a * w_b_ext;
  end

  assign o_p = r_p;

endmodule

// File: rtl/filters_mul_pipe.sv
// Pipelined signed x unsigned multiplier with rounding shift and valid/ready
// handshake. Global-stall pipeline of NUM_STAGE registers.
// Build option: FILTERS_MUL_SAT_EN -> saturate and track ovf_sticky;
// otherwise the result wraps and ovf_sticky stays 0.
module filters_mul_pipe
  import filters_mul_pkg::*;
#(
  parameter int DIN0_W    = 17,
  parameter int DIN1_W    = 15,
  parameter int DOUT_W    = 32,
  parameter int NUM_STAGE = 3,
  parameter int SHIFT     = 0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [DIN0_W-1:0] din0,
  input  logic        [DIN1_W-1:0] din1,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky
);

  localparam int PW = DIN0_W + DIN1_W;

  logic                     w_adv;
  logic [NUM_STAGE-1:0]     r_vld;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_round;
  logic signed [DOUT_W-1:0] w_res;
  logic                     w_ovf;
  logic                     w_out_ovf;

  // Whole pipeline moves together unless the output holds an unaccepted result.
  assign w_adv     = !r_vld[NUM_STAGE-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[NUM_STAGE-1];

  filters_mul_pipe_dsp #(
    .A_W (DIN0_W),
    .B_W (DIN1_W)
  ) u_dsp (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_en    (w_adv),
    .i_a     (din0),
    .i_b     (din1),
    .o_p     (w_prod)
  );

  // Round half toward +inf, then arithmetic shift; done at full precision.
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_round    = (w_prod_ext + round_const(SHIFT)) >>> SHIFT;

`ifdef FILTERS_MUL_SAT_EN
  logic signed [ACC_W-1:0] w_clamped;
  assign w_clamped = saturate(w_round, DOUT_W);
  assign w_res     = w_clamped[DOUT_W-1:0];
  assign w_ovf     = is_sat(w_round, DOUT_W);
`else
  assign w_res = w_round[DOUT_W-1:0];
  assign w_ovf = 1'b0;
`endif

  // One valid bit per stage; bubbles enter as zeros.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  r_vld <= '0;
    else if (w_adv) r_vld <= (r_vld << 1) | NUM_STAGE'(in_valid);
  end

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign dout      = w_res;
      assign w_out_ovf = w_ovf;
    end else begin : g_chain
      logic signed [DOUT_W-1:0] r_res [NUM_STAGE-1];
      logic                     r_ovf [NUM_STAGE-1];
      for (genvar gi = 0; gi < NUM_STAGE - 1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          // Register the scaled result coming out of the multiply stage.
          always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
              r_res[gi] <= '0;
              r_ovf[gi] <= 1'b0;
            end else if (w_adv) begin
              r_res[gi] <= w_res;
              r_ovf[gi] <= w_ovf;
            end
          end
        end else begin : g_next
          // Plain delay stage carrying result and saturation flag.
          always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
              r_res[gi] <= '0;
              r_ovf[gi] <= 1'b0;
            end else if (w_adv) begin
              r_res[gi] <= r_res[gi-1];
              r_ovf[gi] <= r_ovf[gi-1];
            end
          end
        end
      end
      assign dout      = r_res[NUM_STAGE-2];
      assign w_out_ovf = r_ovf[NUM_STAGE-2];
    end
  endgenerate

`ifdef FILTERS_MUL_SAT_EN
  logic r_ovf_sticky;
  // Set on a saturated transfer out; a coincident clear loses to the set.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                                 r_ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && w_out_ovf)  r_ovf_sticky <= 1'b1;
    else if (ovf_clr)                              r_ovf_sticky <= 1'b0;
  end
  assign ovf_sticky = r_ovf_sticky;
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_filters_mul_pipe.sv
// Directed bench for filters_mul_pipe: three instances (defaults, SHIFT=4,
// DOUT_W=16) share one stimulus stream and are checked in lockstep.
module tb_filters_mul_pipe;

`ifdef FILTERS_MUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic signed [16:0] din0;
  logic [14:0] din1;
  logic in_valid;
  logic out_ready;
  logic ovf_clr;

  logic rdy_def, rdy_rnd, rdy_w16;
  logic ov_def, ov_rnd, ov_w16;
  logic osk_def, osk_rnd, osk_w16;
  logic signed [31:0] dout_def;
  logic signed [31:0] dout_rnd;
  logic signed [15:0] dout_w16;

  int n_cmp  = 0;
  int n_fail = 0;

  filters_mul_pipe u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(rdy_def), .dout(dout_def),
    .out_valid(ov_def), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .ovf_sticky(osk_def)
  );

  filters_mul_pipe #(.SHIFT(4)) u_rnd (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(rdy_rnd), .dout(dout_rnd),
    .out_valid(ov_rnd), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .ovf_sticky(osk_rnd)
  );

  filters_mul_pipe #(.DOUT_W(16)) u_w16 (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(rdy_w16), .dout(dout_w16),
    .out_valid(ov_w16), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .ovf_sticky(osk_w16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic signed [63:0] e_def,
                         input logic signed [63:0] e_rnd, input logic signed [63:0] e_w16);
    chk({tag, "_vld_def"}, 64'(ov_def), 64'(v));
    chk({tag, "_vld_rnd"}, 64'(ov_rnd), 64'(v));
    chk({tag, "_vld_w16"}, 64'(ov_w16), 64'(v));
    if (v) begin
      chk({tag, "_dout_def"}, dout_def, e_def);
      chk({tag, "_dout_rnd"}, dout_rnd, e_rnd);
      chk({tag, "_dout_w16"}, dout_w16, e_w16);
    end
    $display("step %s: vld=%0b def=%0d rnd=%0d w16=%0d", tag, ov_def, dout_def, dout_rnd, dout_w16);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int in_idx;
    int out_idx;
    bit saw_block;
    longint bp_def[5];
    longint bp_rnd[5];
    bp_def = '{300, 303, 306, 309, 312};
    bp_rnd = '{19, 19, 19, 19, 20};

    rst_n = 1'b0; din0 = '0; din1 = '0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;

    // Reset state
    #12;
    chk_out("reset", 1'b0, 0, 0, 0);
    chk("reset_dout_def", dout_def, 0);
    chk("reset_dout_w16", dout_w16, 0);
    chk("reset_sticky_w16", 64'(osk_w16), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_in_ready", 64'(rdy_def), 1);

    // Latency: defaults vector, result exactly 3 cycles later
    din0 = -65536; din1 = 32767; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("lat1", 1'b0, 0, 0, 0);
    tick();
    chk_out("lat2", 1'b0, 0, 0, 0);
    tick();
    chk_out("lat3", 1'b1, -2147418112, -134213632, SAT ? -32768 : 0);
    tick();
    chk("lat_sticky_w16", 64'(osk_w16), 64'(SAT));
    chk("lat_sticky_def", 64'(osk_def), 0);
    chk_out("lat_bubble", 1'b0, 0, 0, 0);

    // Back-to-back stream covering rounding cases
    din0 = 1;  din1 = 8; in_valid = 1'b1; tick();
    din0 = -1; din1 = 8; tick();
    din0 = -3; din1 = 8; tick();
    chk_out("rnd_a", 1'b1, 8, 1, 8);
    in_valid = 1'b0; tick();
    chk_out("rnd_b", 1'b1, -8, 0, -8);
    tick();
    chk_out("rnd_c", 1'b1, -24, -1, -24);
    tick();
    chk_out("rnd_end", 1'b0, 0, 0, 0);

    // Clear sticky, then a saturating transfer coinciding with clear
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("clr_sticky_w16", 64'(osk_w16), 0);
    din0 = 65535; din1 = 32767; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();
    chk_out("sat", 1'b1, 2147385345, 134211584, SAT ? 32767 : -32767);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("clr_vs_set_w16", 64'(osk_w16), 64'(SAT));
    chk("clr_vs_set_rnd", 64'(osk_rnd), 0);

    // Backpressure: 5 inputs, out_ready low for the first 5 cycles
    in_idx = 0; out_idx = 0; saw_block = 1'b0;
    for (int c = 0; c < 30 && out_idx < 5; c++) begin
      out_ready = (c >= 5);
      in_valid  = (in_idx < 5);
      din0 = 17'(100 + in_idx); din1 = 15'd3;
      #1;
      if (ov_def) begin
        chk("bp_def", dout_def, bp_def[out_idx]);
        chk("bp_rnd", dout_rnd, bp_rnd[out_idx]);
        chk("bp_w16", dout_w16, bp_def[out_idx]);
        $display("bp cycle %0d: item %0d def=%0d rdy=%0b", c, out_idx, dout_def, out_ready);
      end
      if (in_valid && !rdy_def) saw_block = 1'b1;
      if (in_valid && rdy_def) in_idx++;
      if (ov_def && out_ready) out_idx++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_in_count", in_idx, 5);
    chk("bp_out_count", out_idx, 5);
    chk("bp_stall_seen", 64'(saw_block), 1);
    tick();
    chk_out("bp_drained", 1'b0, 0, 0, 0);

    // Reset with three results in flight
    din0 = 1;  din1 = 8; in_valid = 1'b1; tick();
    din0 = -1; tick();
    din0 = -3; tick();
    in_valid = 1'b0;
    chk_out("inflight", 1'b1, 8, 1, 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 0, 0, 0);
    chk("async_rst_dout", dout_def, 0);
    chk("async_rst_sticky", 64'(osk_w16), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("post_rst", 1'b0, 0, 0, 0);
    end
    chk("post_rst_in_ready", 64'(rdy_def), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
